axi_traffic_gen: RTL and testbench

- Self-checking traffic generator that drives the command interface of axi_master; sits directly upstream of it.
- On start, runs two phases:
  - Write phase: NUM_WORDS single-beat writes of a deterministic pattern.
  - Read phase: the same region is read back as INCR bursts of BURST_LEN+1 beats, and every beat is checked.
- Replaces hand-sequenced bench stimulus and is the bring-up/BIST source for master+slave.

---
 rtl/axi_traffic_gen_if.sv | 29 ++
 rtl/axi_traffic_gen.sv | 190 +++++++++++++++++++
 tb/tb_axi_traffic_gen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_traffic_gen_if.sv
// Command-side bundle between the traffic generator and axi_master.
interface axi_traffic_gen_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_write;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [AXI_DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_W-1:0]         cmd_wstrb;
  logic [7:0]                cmd_len;
  logic [AXI_DATA_WIDTH-1:0] cmd_rdata;
  logic                      cmd_rvalid;
  logic                      cmd_rready;
  logic [1:0]                cmd_resp;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_len, cmd_rready,
    input  cmd_ready, cmd_rdata, cmd_rvalid, cmd_resp
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, cmd_len, cmd_rready,
    output cmd_ready, cmd_rdata, cmd_rvalid, cmd_resp
  );
endinterface

// File: rtl/axi_traffic_gen.sv
// Write-then-readback BIST source for axi_master; optional watchdog via TRAFFIC_GEN_TIMEOUT_EN.
// States: IDLE idle | WR_REQ write cmd | WR_WAIT master busy | RD_REQ burst cmd | RD_DATA check beats | RD_WAIT master busy | DONE result held
module axi_traffic_gen #(
  parameter int          AXI_ADDR_WIDTH = 32,
  parameter int          AXI_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          NUM_WORDS      = 16,
  parameter int          BURST_LEN      = 3,
  parameter logic [31:0] SEED           = 32'hA5A5_0000,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [15:0]               err_count_o,
  output logic [AXI_ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                      timeout_o,
  axi_traffic_gen_if.master         cmd
);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(NUM_WORDS + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(STRB_W);
  localparam logic [AXI_DATA_WIDTH-1:0] DATA_STEP = AXI_DATA_WIDTH'(32'h0101_0101);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR0     = AXI_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [AXI_DATA_WIDTH-1:0] DATA0     = AXI_DATA_WIDTH'(SEED);

  if ((NUM_WORDS % (BURST_LEN + 1)) != 0 || BURST_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("axi_traffic_gen: NUM_WORDS must be a multiple of BURST_LEN+1 (BURST_LEN<=255)");
  end

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_DATA, RD_WAIT, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          idx_q, idx_d;
  logic [7:0]                beat_q, beat_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [15:0]               err_q, err_d;
  logic [AXI_ADDR_WIDTH-1:0] fea_q, fea_d;
  logic                      clr_tmo;
  logic                      more;

`ifdef TRAFFIC_GEN_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_q, timeout_d;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign busy_o           = (state_q != IDLE) && (state_q != DONE);
  assign done_o           = (state_q == DONE);
  assign pass_o           = done_o && (err_q == 16'd0) && !timeout_o;
  assign err_count_o      = err_q;
  assign first_err_addr_o = fea_q;
  assign more             = (idx_q < CNT_W'(NUM_WORDS));

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    beat_d         = beat_q;
    addr_d         = addr_q;
    data_d         = data_q;
    err_d          = err_q;
    fea_d          = fea_q;
    clr_tmo        = 1'b0;
    cmd.cmd_valid  = 1'b0;
    cmd.cmd_write  = 1'b0;
    cmd.cmd_addr   = '0;
    cmd.cmd_wdata  = '0;
    cmd.cmd_wstrb  = '0;
    cmd.cmd_len    = 8'd0;
    cmd.cmd_rready = 1'b0;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
    tmo_cnt_d      = tmo_cnt_q;
    timeout_d      = timeout_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = WR_REQ;
          idx_d   = '0;
          beat_d  = 8'd0;
          addr_d  = ADDR0;
          data_d  = DATA0;
          err_d   = 16'd0;
          fea_d   = '0;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      WR_REQ: begin
        cmd.cmd_valid = 1'b1;
        cmd.cmd_write = 1'b1;
        cmd.cmd_addr  = addr_q;
        cmd.cmd_wdata = data_q;
        cmd.cmd_wstrb = '1;
        if (cmd.cmd_ready) begin
          clr_tmo = 1'b1;
          idx_d   = idx_q + 1'b1;
          addr_d  = addr_q + ADDR_STEP;
          data_d  = data_q + DATA_STEP;
          state_d = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (cmd.cmd_ready) begin
          if (more) begin
            state_d = WR_REQ;
          end else begin
            // read phase walks the same region again from word 0
            idx_d   = '0;
            addr_d  = ADDR0;
            data_d  = DATA0;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        cmd.cmd_valid  = 1'b1;
        cmd.cmd_len    = 8'(BURST_LEN);
        cmd.cmd_addr   = addr_q;
        cmd.cmd_rready = 1'b1;
        if (cmd.cmd_ready) begin
          clr_tmo = 1'b1;
          beat_d  = 8'd0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        cmd.cmd_rready = 1'b1;
        if (cmd.cmd_rvalid) begin
          clr_tmo = 1'b1;
          if ((cmd.cmd_rdata != data_q) || (cmd.cmd_resp != 2'b00)) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) fea_d = addr_q;
          end
          idx_d  = idx_q + 1'b1;
          addr_d = addr_q + ADDR_STEP;
          data_d = data_q + DATA_STEP;
          if (beat_q == 8'(BURST_LEN)) state_d = RD_WAIT;
          else                         beat_d  = beat_q + 8'd1;
        end
      end
      RD_WAIT: begin
        if (cmd.cmd_ready) state_d = more ? RD_REQ : DONE;
      end
      default: state_d = IDLE;
    endcase
`ifdef TRAFFIC_GEN_TIMEOUT_EN
    tmo_cnt_d = (clr_tmo || !busy_o) ? 32'd0 : tmo_cnt_q + 32'd1;
    if (busy_o && !clr_tmo && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1))) begin
      state_d   = DONE;
      timeout_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      beat_q  <= 8'd0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 16'd0;
      fea_q   <= '0;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
      tmo_cnt_q <= 32'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end
endmodule

// File: tb/tb_axi_traffic_gen.sv
// Scoreboard bench for axi_traffic_gen with a small behavioural axi_master/slave stand-in.
module tb_axi_traffic_gen;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef TRAFFIC_GEN_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 1000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  axi_traffic_gen_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

  axi_traffic_gen #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_count),
    .first_err_addr_o (first_err_addr),
    .timeout_o        (timeout),
    .cmd              (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {logic wr; logic [31:0] addr; logic [31:0] data; logic [7:0] len;} cmd_t;
  typedef struct {logic [15:0] err; logic [31:0] fea; logic pass;} res_t;
  cmd_t exp_cmd_q[$];
  res_t exp_res_q[$];

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural master/slave stand-in ----------------
  logic [31:0] mem [64];
  int   s_state = 0, s_wait = 0, s_beat = 0, g_beat = 0, stall_cnt = 0;
  int   flip_beat = -1, resp_a = -1, resp_b = -1;
  bit   stall_en = 0, stall_done = 0, hold_low = 0;
  cmd_t s_cmd;

  initial begin
    bus.cmd_ready = 1'b0; bus.cmd_rvalid = 1'b0; bus.cmd_rdata = '0; bus.cmd_resp = 2'b00;
  end

  always @(negedge clk) begin
    if (rst) begin
      s_state = 0; bus.cmd_ready = 1'b0; bus.cmd_rvalid = 1'b0; bus.cmd_resp = 2'b00;
    end else begin
      case (s_state)
        0: begin
          bus.cmd_rvalid = 1'b0;
          if (hold_low) bus.cmd_ready = 1'b0;
          else if (stall_cnt > 0) begin
            bus.cmd_ready = 1'b0;
            stall_cnt--;
            check("stall_hold", {bus.cmd_valid, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 32'h0C, pat(3)});
          end else if (stall_en && !stall_done && bus.cmd_valid && bus.cmd_write && bus.cmd_addr == 32'h0C) begin
            stall_done = 1; stall_cnt = 19; bus.cmd_ready = 1'b0;
          end else begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
              s_cmd = '{bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_len};
              s_state = 1;
            end
          end
        end
        1: begin
          bus.cmd_ready = 1'b0;
          if (s_cmd.wr) begin
            mem[(s_cmd.addr >> 2) & 63] = s_cmd.data; s_wait = 2; s_state = 2;
          end else begin
            s_beat = 0; s_state = 3;
          end
        end
        2: if (s_wait > 0) s_wait--; else begin bus.cmd_ready = 1'b1; s_state = 0; end
        default: begin
          if (s_beat <= int'(s_cmd.len)) begin
            if (bus.cmd_rready) begin
              bus.cmd_rvalid = 1'b1;
              bus.cmd_rdata  = mem[((s_cmd.addr >> 2) + 32'(s_beat)) & 63] ^ ((g_beat == flip_beat) ? 32'd1 : 32'd0);
              bus.cmd_resp   = (g_beat == resp_a || g_beat == resp_b) ? 2'b10 : 2'b00;
              g_beat++; s_beat++;
            end else bus.cmd_rvalid = 1'b0;
          end else begin
            bus.cmd_rvalid = 1'b0; bus.cmd_ready = 1'b1; s_state = 0;
          end
        end
      endcase
    end
  end

  // ---------------- monitor ----------------
  bit done_seen = 0;
  always begin
    @(negedge clk); #3;
    if (!rst && bus.cmd_valid && bus.cmd_ready) begin
      if (exp_cmd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL cmd_unexpected: got addr %0h write %0b, required none", bus.cmd_addr, bus.cmd_write);
      end else begin
        cmd_t e;
        e = exp_cmd_q.pop_front();
        if (e.wr)
          check("wr_cmd", {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb, bus.cmd_len},
                          {1'b1, e.addr, e.data, 4'hF, 8'd0});
        else
          check("rd_cmd", {bus.cmd_write, bus.cmd_addr, bus.cmd_len, bus.cmd_rready},
                          {1'b0, e.addr, e.len, 1'b1});
      end
    end
    if (!rst && done && !done_seen) begin
      done_seen = 1;
      if (exp_res_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL done_unexpected: got done=1, required no result");
      end else begin
        res_t r;
        r = exp_res_q.pop_front();
        check("result", {err_count, first_err_addr, pass, busy}, {r.err, r.fea, r.pass, 1'b0});
      end
    end
    if (!done) done_seen = 0;
  end

  // ---------------- stimulus ----------------
  task automatic push_run(input logic [15:0] err, input logic [31:0] fea, input logic p);
    for (int i = 0; i < 16; i++) exp_cmd_q.push_back('{1'b1, 32'(i * 4), pat(i), 8'd0});
    for (int b = 0; b < 4; b++) exp_cmd_q.push_back('{1'b0, 32'(b * 16), 32'd0, 8'd3});
    exp_res_q.push_back('{err, fea, p});
  endtask

  task automatic prep();
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    g_beat = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c;
    for (c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got done=0 after 3000 cycles, required done=1", name);
    end
    repeat (2) @(negedge clk);
    check({name, "_drained"}, {32'(exp_cmd_q.size()), 32'(exp_res_q.size())}, 64'd0);
  endtask

  task automatic check_zero(input string name);
    check(name, {busy, done, pass, err_count, first_err_addr, timeout, bus.cmd_valid, bus.cmd_write,
                 bus.cmd_addr, bus.cmd_wdata, bus.cmd_wstrb, bus.cmd_len, bus.cmd_rready}, 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;

    // nominal run, with first-command latency and start-while-busy
    prep();
    push_run(16'd0, 32'h0, 1'b1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("first_cmd", {bus.cmd_valid, busy, bus.cmd_addr, bus.cmd_wdata}, {1'b1, 1'b1, 32'h0, 32'hA5A5_0000});
    repeat (4) @(negedge clk);
    pulse_start();
    wait_done("nominal");

    // single corrupted data beat
    prep(); flip_beat = 5;
    push_run(16'd1, 32'h14, 1'b0);
    pulse_start();
    wait_done("flip_beat5");
    flip_beat = -1;

    // two error responses
    prep(); resp_a = 2; resp_b = 9;
    push_run(16'd2, 32'h08, 1'b0);
    pulse_start();
    wait_done("resp_err");
    resp_a = -1; resp_b = -1;

    // master stalls on word 3
    prep(); stall_en = 1; stall_done = 0;
    push_run(16'd0, 32'h0, 1'b1);
    pulse_start();
    wait_done("stall_w3");
    stall_en = 0;

    // reset in burst 2, then rerun
    prep();
    push_run(16'd0, 32'h0, 1'b1);
    void'(exp_res_q.pop_back());
    pulse_start();
    for (int c = 0; c < 3000 && exp_cmd_q.size() > 1; c++) @(negedge clk);
    @(negedge clk);
    check("mid_burst2", {busy, bus.cmd_rready, 32'(exp_cmd_q.size())}, {1'b1, 1'b1, 32'd1});
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_run");
    exp_cmd_q.delete();
    rst = 1'b0;
    prep();
    push_run(16'd0, 32'h0, 1'b1);
    pulse_start();
    wait_done("rerun");

`ifdef TRAFFIC_GEN_TIMEOUT_EN
    begin
      int c;
      hold_low = 1;
      exp_res_q.push_back('{16'd0, 32'h0, 1'b0});
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (c = 0; c < 200 && !timeout; c++) @(negedge clk);
      check("timeout_latency", {32'(c), timeout, done, pass, bus.cmd_valid}, {32'd50, 1'b1, 1'b1, 1'b0, 1'b0});
      repeat (2) @(negedge clk);
      hold_low = 0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
